// File: rtl/regfile_scoreboard_if.sv
// Register file bus: read, dual write and claim signals.
// The datapath side drives addresses, writes and claims; the file answers.
interface regfile_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8
);
  logic [REG_ADDR_WIDTH-1:0] rd_addr1;
  logic [REG_ADDR_WIDTH-1:0] rd_addr2;
  logic [DATA_WIDTH-1:0]     rd_data1;
  logic [DATA_WIDTH-1:0]     rd_data2;
  logic                      rd_busy1;
  logic                      rd_busy2;
  logic                      wr_en_a;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_a;
  logic [DATA_WIDTH-1:0]     wr_data_a;
  logic                      wr_en_b;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_b;
  logic [DATA_WIDTH-1:0]     wr_data_b;
  logic                      claim_en;
  logic [REG_ADDR_WIDTH-1:0] claim_addr;
  logic [REG_ADDR_WIDTH:0]   busy_count;

  modport master (
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output claim_en, claim_addr,
    input  busy_count
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2, rd_busy1, rd_busy2,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  claim_en, claim_addr,
    output busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Dual-write, dual-read register file with busy scoreboard.
// Optional same-cycle bypass and hardwired-zero register 0.
module regfile_scoreboard #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  data_t                   regs [NUM_REGS];
  logic [NUM_REGS-1:0]     busy;
  logic [NUM_REGS-1:0]     busy_nxt;
  logic [REG_ADDR_WIDTH:0] cnt;
  logic [REG_ADDR_WIDTH:0] busy_count_q;

  logic  wa_en;
  logic  wb_en;
  logic  cl_en;
  addr_t ra [2];
  data_t rd [2];
  logic  rb [2];

  // Drop writes and claims aimed at the hardwired zero register
  always_comb begin
    wa_en = bus.wr_en_a  && !(ZR && bus.wr_addr_a  == '0);
    wb_en = bus.wr_en_b  && !(ZR && bus.wr_addr_b  == '0);
    cl_en = bus.claim_en && !(ZR && bus.claim_addr == '0);
  end

  // Storage update; port B is applied last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wa_en) regs[bus.wr_addr_a] <= bus.wr_data_a;
      if (wb_en) regs[bus.wr_addr_b] <= bus.wr_data_b;
    end
  end

  // Next busy vector: writes clear, a same-cycle claim re-sets
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wa_en && bus.wr_addr_a == addr_t'(i)) busy_nxt[i] = 1'b0;
      if (wb_en && bus.wr_addr_b == addr_t'(i)) busy_nxt[i] = 1'b0;
      if (cl_en && bus.claim_addr == addr_t'(i)) busy_nxt[i] = 1'b1;
    end
  end

  // Popcount of the next busy vector
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt = cnt + (REG_ADDR_WIDTH+1)'(busy_nxt[i]);
  end

  // Scoreboard and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      busy_count_q <= '0;
    end else begin
      busy         <= busy_nxt;
      busy_count_q <= cnt;
    end
  end

  assign ra[0] = bus.rd_addr1;
  assign ra[1] = bus.rd_addr2;

  // Read ports: stored value, optionally overridden by this cycle's write
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = regs[ra[p]];
      rb[p] = busy[ra[p]];
      if (BP) begin
        if (wa_en && bus.wr_addr_a == ra[p]) begin
          rd[p] = bus.wr_data_a;
          rb[p] = 1'b0;
        end
        if (wb_en && bus.wr_addr_b == ra[p]) begin
          rd[p] = bus.wr_data_b;
          rb[p] = 1'b0;
        end
      end
      if (ZR && ra[p] == '0) begin
        rd[p] = '0;
        rb[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data1   = rd[0];
  assign bus.rd_data2   = rd[1];
  assign bus.rd_busy1   = rb[0];
  assign bus.rd_busy2   = rb[1];
  assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances
// driven in lockstep, checked by a queue-fed monitor.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8)) b0 ();
  regfile_scoreboard_if #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8)) b1 ();

  regfile_scoreboard #(
    .REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .BYPASS(1), .ZERO_REG(1)
  ) dut_bp (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  regfile_scoreboard #(
    .REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  assign b1.rd_addr1   = b0.rd_addr1;
  assign b1.rd_addr2   = b0.rd_addr2;
  assign b1.wr_en_a    = b0.wr_en_a;
  assign b1.wr_addr_a  = b0.wr_addr_a;
  assign b1.wr_data_a  = b0.wr_data_a;
  assign b1.wr_en_b    = b0.wr_en_b;
  assign b1.wr_addr_b  = b0.wr_addr_b;
  assign b1.wr_data_b  = b0.wr_data_b;
  assign b1.claim_en   = b0.claim_en;
  assign b1.claim_addr = b0.claim_addr;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // sel 0..4 = bypass instance, 8..12 = non-bypass instance
  function automatic int get(int sel);
    case (sel)
      0:  return int'(b0.rd_data1);
      1:  return int'(b0.rd_data2);
      2:  return int'(b0.rd_busy1);
      3:  return int'(b0.rd_busy2);
      4:  return int'(b0.busy_count);
      8:  return int'(b1.rd_data1);
      9:  return int'(b1.rd_data2);
      10: return int'(b1.rd_busy1);
      11: return int'(b1.rd_busy2);
      12: return int'(b1.busy_count);
      default: return -1;
    endcase
  endfunction

  task automatic expect_v(string n, int sel, int v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int   got;
      e   = q.pop_front();
      got = get(e.sel);
      n_vec++;
      if (got !== e.val) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h",
                 e.name, got, e.val);
      end
    end
  end

  task automatic idle();
    rst           = 1'b0;
    b0.wr_en_a    = 1'b0;
    b0.wr_addr_a  = '0;
    b0.wr_data_a  = '0;
    b0.wr_en_b    = 1'b0;
    b0.wr_addr_b  = '0;
    b0.wr_data_b  = '0;
    b0.claim_en   = 1'b0;
    b0.claim_addr = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wa(int a, int d);
    b0.wr_en_a   = 1'b1;
    b0.wr_addr_a = 4'(a);
    b0.wr_data_a = 8'(d);
  endtask

  task automatic wb(int a, int d);
    b0.wr_en_b   = 1'b1;
    b0.wr_addr_b = 4'(a);
    b0.wr_data_b = 8'(d);
  endtask

  task automatic cl(int a);
    b0.claim_en   = 1'b1;
    b0.claim_addr = 4'(a);
  endtask

  task automatic rd(int a1, int a2);
    b0.rd_addr1 = 4'(a1);
    b0.rd_addr2 = 4'(a2);
  endtask

  initial begin
    idle();
    rd(0, 0);
    rst = 1'b1;
    next();
    // preload
    wa(3, 8'hAA); wb(9, 8'hBB); cl(10);
    next();
    cl(9); rd(3, 9);
    expect_v("preload_r3", 0, 8'hAA);
    expect_v("preload_r9", 1, 8'hBB);
    expect_v("preload_cnt", 4, 1);
    next();
    // reset with a write and claim that must be ignored
    rst = 1'b1; wa(1, 8'h77); cl(5);
    next();
    rd(1, 9);
    expect_v("rst_r1_data", 0, 0);
    expect_v("rst_r9_data", 1, 0);
    expect_v("rst_r9_busy", 3, 0);
    expect_v("rst_cnt", 4, 0);
    expect_v("rst_cnt_nb", 12, 0);
    next();
    // dual write, different registers
    wa(3, 8'h5A); wb(7, 8'hC3); rd(3, 7);
    expect_v("dual_byp_r3", 0, 8'h5A);
    expect_v("dual_byp_r7", 1, 8'hC3);
    expect_v("dual_nb_r3_old", 8, 0);
    next();
    rd(3, 7);
    expect_v("dual_hold_r3", 0, 8'h5A);
    expect_v("dual_hold_r7", 1, 8'hC3);
    expect_v("dual_nb_r7", 9, 8'hC3);
    next();
    // collision: B wins
    wa(5, 8'h11); wb(5, 8'h22); rd(5, 0);
    expect_v("coll_byp", 0, 8'h22);
    next();
    rd(5, 0);
    expect_v("coll_store", 0, 8'h22);
    expect_v("coll_store_nb", 8, 8'h22);
    next();
    // scoreboard lifecycle on r4
    cl(4); rd(4, 0);
    expect_v("claim_same_cyc", 2, 0);
    expect_v("claim_cnt0", 4, 0);
    next();
    rd(4, 0);
    expect_v("claim_busy", 2, 1);
    expect_v("claim_cnt1", 4, 1);
    next();
    wa(4, 8'h9E); rd(4, 0);
    expect_v("wb_busy_byp", 2, 0);
    expect_v("wb_data_byp", 0, 8'h9E);
    expect_v("wb_busy_nb", 10, 1);
    expect_v("wb_data_nb", 8, 0);
    expect_v("wb_cnt_pre", 4, 1);
    next();
    rd(4, 0);
    expect_v("wb_cnt_post", 4, 0);
    expect_v("wb_busy_post", 2, 0);
    expect_v("wb_data_post", 0, 8'h9E);
    next();
    // claim and write same register together
    cl(2);
    next();
    cl(2); wb(2, 8'h40); rd(0, 2);
    expect_v("cw_busy_byp", 3, 0);
    expect_v("cw_cnt_pre", 4, 1);
    next();
    rd(0, 2);
    expect_v("cw_data", 1, 8'h40);
    expect_v("cw_busy", 3, 1);
    expect_v("cw_cnt", 4, 1);
    next();
    // zero register
    wa(0, 8'hFF); cl(0); rd(0, 0);
    expect_v("r0_data_byp", 0, 0);
    expect_v("r0_busy_byp", 2, 0);
    next();
    rd(0, 0);
    expect_v("r0_data", 0, 0);
    expect_v("r0_busy", 2, 0);
    expect_v("r0_cnt", 4, 1);
    next();
    // non-bypass visibility delay
    wb(6, 8'h33); rd(6, 0);
    expect_v("nb_r6_old", 8, 0);
    expect_v("byp_r6_new", 0, 8'h33);
    next();
    rd(6, 0);
    expect_v("nb_r6_new", 8, 8'h33);
    next();
    // re-claim and count
    cl(8);
    next();
    cl(8); wa(2, 8'h01);
    next();
    rd(8, 2);
    expect_v("reclaim_cnt", 4, 1);
    expect_v("reclaim_busy8", 2, 1);
    expect_v("reclaim_busy2", 3, 0);
    expect_v("reclaim_cnt_nb", 12, 1);
    next();
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
